iq_sample_player: RTL and testbench

//  Synthesisable IQ baseband sample source for the dot11 receiver. Replays a RAM-held

---
 rtl/iq_sample_player.sv | 170 +++++++++++++++++
 tb/tb_iq_sample_player.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_sample_player.sv
// IQ baseband sample source: replays a RAM-held capture as a strobed
// {I, Q} stream at a programmable divider, one-shot or looped with gaps.
module iq_sample_player #(
    parameter int IQ_WIDTH   = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int SR_BASE    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic                    wr_stb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [2*IQ_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic                    abort,
    output logic [2*IQ_WIDTH-1:0]   sample_out,
    output logic                    sample_out_strobe,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             sample_count,
    output logic [15:0]             loop_count
);

    localparam int SW = 2 * IQ_WIDTH;
    localparam int LW = ADDR_WIDTH + 1;

    localparam logic [7:0] A_DIV  = 8'(SR_BASE);
    localparam logic [7:0] A_LEN  = 8'(SR_BASE + 1);
    localparam logic [7:0] A_MODE = 8'(SR_BASE + 2);
    localparam logic [7:0] A_GAP  = 8'(SR_BASE + 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t state, state_nx;

    logic [7:0]    div_r, div_s, div_eff, divider;
    logic [LW-1:0] len_r, len_s, rd_addr;
    logic          loop_r, loop_s;
    logic [15:0]   gap_r, gap_s, gap_cnt;
    logic [SW-1:0] rd_data;

    logic accept, tick, last_sample, last_gap;
    logic strobe_d, done_d, wrap_d;

    logic [SW-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_r  <= 8'd9;
            len_r  <= '0;
            loop_r <= 1'b0;
            gap_r  <= '0;
        end else if (set_stb) begin
            case (set_addr)
                A_DIV:   div_r  <= set_data[7:0];
                A_LEN:   len_r  <= set_data[LW-1:0];
                A_MODE:  loop_r <= set_data[0];
                A_GAP:   gap_r  <= set_data[15:0];
                default: ;
            endcase
        end
    end

    // Registered read; the address is stable at least one cycle before each tick.
    always_ff @(posedge clock) begin
        if (wr_stb)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr[ADDR_WIDTH-1:0]];
    end

    assign accept = (state == S_IDLE) && start && !abort
                    && (len_r != '0) && enable;
    assign div_eff = (div_s < 8'd2) ? 8'd1 : div_s;
    assign tick = (state != S_IDLE) && enable && (divider == div_eff);
    assign last_sample = ((rd_addr + LW'(1)) == len_s);
    assign last_gap = ((gap_cnt + 16'd1) == gap_s);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_nx = S_PLAY;
                S_PLAY: begin
                    if (tick && last_sample) begin
                        if (!loop_s)
                            state_nx = S_IDLE;
                        else if (gap_s != '0)
                            state_nx = S_GAP;
                        else
                            state_nx = S_PLAY;
                    end
                end
                S_GAP: if (tick && last_gap) state_nx = S_PLAY;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        strobe_d = tick && !abort;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        if (strobe_d && (state == S_PLAY) && last_sample) begin
            done_d = !loop_s;
            wrap_d = loop_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_s             <= 8'd9;
            len_s             <= '0;
            loop_s            <= 1'b0;
            gap_s             <= '0;
            divider           <= '0;
            rd_addr           <= '0;
            gap_cnt           <= '0;
            sample_out        <= '0;
            sample_out_strobe <= 1'b0;
            done              <= 1'b0;
            sample_count      <= '0;
            loop_count        <= '0;
        end else begin
            sample_out_strobe <= strobe_d;
            done              <= done_d;
            if (accept) begin
                div_s        <= div_r;
                len_s        <= len_r;
                loop_s       <= loop_r;
                gap_s        <= gap_r;
                divider      <= '0;
                rd_addr      <= '0;
                gap_cnt      <= '0;
                sample_count <= '0;
                loop_count   <= '0;
            end else begin
                if (state != S_IDLE && enable)
                    divider <= tick ? 8'd0 : divider + 8'd1;
                if (strobe_d && state == S_PLAY)
                    rd_addr <= last_sample ? '0 : rd_addr + LW'(1);
                if (strobe_d && state == S_GAP)
                    gap_cnt <= last_gap ? 16'd0 : gap_cnt + 16'd1;
                if (strobe_d && sample_count != '1)
                    sample_count <= sample_count + 32'd1;
                if (wrap_d)
                    loop_count <= loop_count + 16'd1;
            end
            if (strobe_d)
                sample_out <= (state == S_PLAY) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_iq_sample_player.sv
// Bench for iq_sample_player: directed scenarios plus randomized configs
// checked against an edge-counting reference model.
module tb_iq_sample_player;

    localparam int IQW = 16;
    localparam int AW  = 14;
    localparam int SRB = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          start;
    logic          abort;
    logic [31:0]   sample_out;
    logic          sample_out_strobe;
    logic          busy;
    logic          done;
    logic [31:0]   sample_count;
    logic [15:0]   loop_count;

    iq_sample_player #(
        .IQ_WIDTH(IQW),
        .ADDR_WIDTH(AW),
        .SR_BASE(SRB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .set_stb(set_stb),
        .set_addr(set_addr),
        .set_data(set_data),
        .wr_stb(wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .abort(abort),
        .sample_out(sample_out),
        .sample_out_strobe(sample_out_strobe),
        .busy(busy),
        .done(done),
        .sample_count(sample_count),
        .loop_count(loop_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ram [0:63];
    int          obs_c[$];
    int          exp_c[$];
    int          done_c[$];
    logic [31:0] obs_v[$];
    logic [31:0] exp_v[$];
    logic        busy_at [0:1023];

    task automatic check(string tag, logic [63:0] o, logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_reg(int a, int d);
        set_stb  = 1'b1;
        set_addr = 8'(SRB + a);
        set_data = 32'(d);
        @(negedge clock);
        set_stb  = 1'b0;
    endtask

    task automatic config_all(int div, int len, int lp, int gap);
        set_reg(0, div);
        set_reg(1, len);
        set_reg(2, lp);
        set_reg(3, gap);
    endtask

    task automatic wr_ram(int a, logic [31:0] d);
        wr_stb  = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        ram[a]  = d;
        @(negedge clock);
        wr_stb  = 1'b0;
    endtask

    // Start is sampled at edge 0; edge e's outputs are observed at the next negedge.
    task automatic play(int ncyc, int abort_e, int p_lo, int p_hi, int restart_e);
        obs_c.delete();
        obs_v.delete();
        done_c.delete();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        busy_at[0] = busy;
        for (int e = 1; e <= ncyc; e++) begin
            abort  = (e == abort_e);
            start  = (e == abort_e) || (e == restart_e);
            enable = !(e >= p_lo && e <= p_hi);
            @(posedge clock);
            @(negedge clock);
            if (sample_out_strobe) begin
                obs_c.push_back(e);
                obs_v.push_back(sample_out);
            end
            if (done)
                done_c.push_back(e);
            busy_at[e] = busy;
        end
        abort  = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
    endtask

    // Strobe j lands on the edge where enabled-edge count reaches j*period.
    task automatic model(int div, int len, int lp, int gap, int ncyc,
                         int abort_e, int p_lo, int p_hi, output int done_e);
        int period, en, j, total, k;
        exp_c.delete();
        exp_v.delete();
        period = ((div < 2) ? 1 : div) + 1;
        total  = lp ? 1000000 : len;
        en     = 0;
        j      = 0;
        done_e = -1;
        for (int e = 1; e <= ncyc; e++) begin
            if (abort_e > 0 && e >= abort_e)
                break;
            if (!(e >= p_lo && e <= p_hi)) begin
                en++;
                if (en % period == 0 && j < total) begin
                    k = j % (len + gap);
                    exp_c.push_back(e);
                    exp_v.push_back(k < len ? ram[k] : 32'd0);
                    j++;
                    if (!lp && j == len)
                        done_e = e;
                end
            end
        end
    endtask

    task automatic compare(string tag, int done_e, int lp, int len, int gap);
        int n;
        n = exp_c.size();
        check({tag, ":count"}, obs_c.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obs_c.size()) begin
                check($sformatf("%s:cyc%0d", tag, i), obs_c[i], exp_c[i]);
                check($sformatf("%s:val%0d", tag, i), obs_v[i], exp_v[i]);
            end
        end
        check({tag, ":done_n"}, done_c.size(), (done_e >= 0) ? 1 : 0);
        if (done_e >= 0 && done_c.size() > 0)
            check({tag, ":done_cyc"}, done_c[0], done_e);
        check({tag, ":sample_count"}, sample_count, n);
        if (lp != 0)
            check({tag, ":loop_count"}, loop_count, (n + gap) / (len + gap));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    initial begin
        int de, div, len, lp, gap;
        reset    = 1'b1;
        enable   = 1'b1;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        wr_stb   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        @(negedge clock);
        check("rst:sample_out", sample_out, 0);
        check("rst:strobe", sample_out_strobe, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:sample_count", sample_count, 0);
        check("rst:loop_count", loop_count, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 4; i++)
            wr_ram(i, 32'(i + 1));

        // One-shot, DIV=9, LEN=4
        config_all(9, 4, 0, 0);
        model(9, 4, 0, 0, 50, -1, -1, -1, de);
        play(50, -1, -1, -1, -1);
        compare("t1", de, 0, 4, 0);
        check("t1:busy39", busy_at[39], 1);
        check("t1:busy41", busy_at[41], 0);

        // Abort (with simultaneous start) on the cycle of the second strobe
        model(9, 4, 0, 0, 50, 21, -1, -1, de);
        play(50, 21, -1, -1, -1);
        compare("t4", de, 0, 4, 0);
        check("t4:busy21", busy_at[21], 0);
        check("t4:hold", sample_out, 32'd2);

        // Pause for seven edges between strobes 2 and 3
        model(9, 4, 0, 0, 60, -1, 21, 27, de);
        play(60, -1, 21, 27, -1);
        compare("t5", de, 0, 4, 0);
        check("t5:third", obs_c.size() > 2 ? obs_c[2] : -1, 37);

        // Looped with gap
        config_all(4, 3, 1, 2);
        model(4, 3, 1, 2, 50, -1, -1, -1, de);
        play(50, -1, -1, -1, -1);
        compare("t2", de, 1, 3, 2);
        do_abort();
        check("t2:busy_after_abort", busy, 0);

        // Reset mid-play, then LEN=0 start, then start while busy
        config_all(9, 4, 0, 0);
        play(15, -1, -1, -1, -1);
        reset = 1'b1;
        #1;
        check("t6:rst_strobe", sample_out_strobe, 0);
        check("t6:rst_busy", busy, 0);
        check("t6:rst_out", sample_out, 0);
        check("t6:rst_cnt", sample_count, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        model(9, 0, 0, 0, 30, -1, -1, -1, de);
        play(30, -1, -1, -1, -1);
        compare("t6len0", de, 0, 0, 0);
        check("t6len0:busy", busy_at[5], 0);
        set_reg(1, 4);
        model(9, 4, 0, 0, 50, -1, -1, -1, de);
        play(50, -1, -1, -1, 5);
        compare("t6restart", de, 0, 4, 0);

        // Minimum divider with random data
        for (int i = 0; i < 8; i++)
            wr_ram(i, $urandom);
        config_all(0, 8, 0, 0);
        model(0, 8, 0, 0, 25, -1, -1, -1, de);
        play(25, -1, -1, -1, -1);
        compare("t3", de, 0, 8, 0);

        // Randomized configurations
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(0, 5);
            len = $urandom_range(1, 6);
            lp  = $urandom_range(0, 1);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < len; i++)
                wr_ram(i, $urandom);
            config_all(div, len, lp, gap);
            model(div, len, lp, gap, 70, -1, -1, -1, de);
            play(70, -1, -1, -1, -1);
            compare($sformatf("rnd%0d", r), de, lp, len, gap);
            do_abort();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
